// File: rtl/debug_mem_loader.sv
// Debug loader: streams words from the host into instruction memory (with an XOR
// readback verify) or dumps data memory to the host, holding the core in reset meanwhile.
module debug_mem_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic [31:0] inst_a2,
    output logic [31:0] inst_wd2,
    output logic [3:0]  inst_we2,
    input  logic [31:0] inst_rd2,
    output logic [31:0] data_a2,
    output logic [31:0] data_wd2,
    output logic [3:0]  data_we2,
    input  logic [31:0] data_rd2,
    output logic        cpu_rst_req,
    output logic        busy,
    output logic        done,
    output logic        verify_err,
    output logic [3:0]  state_dbg
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] LOAD      = 4'd1;
    localparam logic [3:0] LOAD_LAST = 4'd2;
    localparam logic [3:0] VRFY_RD   = 4'd3;
    localparam logic [3:0] VRFY_CMP  = 4'd4;
    localparam logic [3:0] DUMP_RD   = 4'd5;
    localparam logic [3:0] DUMP_CAP  = 4'd6;
    localparam logic [3:0] DUMP_OUT  = 4'd7;
    localparam logic [3:0] DONE      = 4'd8;

    logic [3:0]  state;
    logic [31:0] base_q;
    logic [15:0] count_q;
    logic [15:0] idx;
    logic [31:0] wr_sum;
    logic [31:0] rd_sum;

    logic [15:0] idx_inc;
    logic        last;
    logic [31:0] addr_cur;
    logic [31:0] addr_nxt;
    logic [31:0] rd_sum_nxt;

    always_comb begin
        idx_inc    = idx + 16'd1;
        last       = (idx_inc == count_q);
        addr_cur   = base_q + {14'd0, idx, 2'b00};
        addr_nxt   = base_q + {14'd0, idx_inc, 2'b00};
        rd_sum_nxt = rd_sum ^ inst_rd2;
    end

    // Handshakes: a word moves on a rising edge where valid and ready are both 1;
    // out_valid/out_data never change while out_valid is 1 and out_ready is 0.
    assign in_ready    = (state == LOAD);
    assign out_valid   = (state == DUMP_OUT);
    assign busy        = (state != IDLE);
    assign cpu_rst_req = busy;
    assign done        = (state == DONE);
    assign data_wd2    = 32'd0;
    assign data_we2    = 4'h0;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_q     <= 32'd0;
            count_q    <= 16'd0;
            idx        <= 16'd0;
            wr_sum     <= 32'd0;
            rd_sum     <= 32'd0;
            verify_err <= 1'b0;
            inst_a2    <= 32'd0;
            inst_wd2   <= 32'd0;
            inst_we2   <= 4'h0;
            data_a2    <= 32'd0;
            out_data   <= 32'd0;
        end else begin
            inst_we2 <= 4'h0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= {base_addr[31:2], 2'b00};
                        count_q    <= word_count;
                        idx        <= 16'd0;
                        wr_sum     <= 32'd0;
                        rd_sum     <= 32'd0;
                        verify_err <= 1'b0;
                        if (word_count == 16'd0) begin
                            state <= DONE;
                        end else if (mode) begin
                            data_a2 <= {base_addr[31:2], 2'b00};
                            state   <= DUMP_RD;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        inst_a2  <= addr_cur;
                        inst_wd2 <= in_data;
                        inst_we2 <= 4'hF;
                        wr_sum   <= wr_sum ^ in_data;
                        if (last) begin
                            idx   <= 16'd0;
                            state <= LOAD_LAST;
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
                // The final write is on the bus this cycle; the verify address follows it.
                LOAD_LAST: begin
                    inst_a2 <= base_q;
                    state   <= VRFY_RD;
                end
                VRFY_RD: state <= VRFY_CMP;
                VRFY_CMP: begin
                    rd_sum <= rd_sum_nxt;
                    idx    <= idx_inc;
                    if (last) begin
                        verify_err <= (wr_sum != rd_sum_nxt);
                        state      <= DONE;
                    end else begin
                        inst_a2 <= addr_nxt;
                        state   <= VRFY_RD;
                    end
                end
                DUMP_RD: state <= DUMP_CAP;
                DUMP_CAP: begin
                    out_data <= data_rd2;
                    state    <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (out_ready) begin
                        idx <= idx_inc;
                        if (last) begin
                            state <= DONE;
                        end else begin
                            data_a2 <= addr_nxt;
                            state   <= DUMP_RD;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_mem_loader.sv
// Bench for debug_mem_loader: memory models for both debug ports, write/dump
// scoreboards checked every cycle, and directed load/dump/reset/wrap scenarios.
module tb_debug_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [31:0] inst_a2;
    logic [31:0] inst_wd2;
    logic [3:0]  inst_we2;
    logic [31:0] inst_rd2;
    logic [31:0] data_a2;
    logic [31:0] data_wd2;
    logic [3:0]  data_we2;
    logic [31:0] data_rd2;
    logic        cpu_rst_req;
    logic        busy;
    logic        done;
    logic        verify_err;
    logic [3:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    logic [63:0] exp_wr[$];
    logic [31:0] exp_out[$];
    logic [31:0] words_q[$];
    logic [31:0] addrs_q[$];

    logic [31:0] imem[logic [31:0]];
    logic [31:0] dmem[logic [31:0]];
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'd0;
    logic [31:0] corrupt_val = 32'd0;

    debug_mem_loader dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .inst_a2(inst_a2), .inst_wd2(inst_wd2), .inst_we2(inst_we2), .inst_rd2(inst_rd2),
        .data_a2(data_a2), .data_wd2(data_wd2), .data_we2(data_we2), .data_rd2(data_rd2),
        .cpu_rst_req(cpu_rst_req), .busy(busy), .done(done), .verify_err(verify_err),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // synchronous memories: read data is valid the cycle after the address
    always @(posedge clk) begin
        if (inst_we2 == 4'hF) imem[inst_a2] = inst_wd2;
        if (corrupt_en && inst_a2 == corrupt_addr) inst_rd2 <= corrupt_val;
        else inst_rd2 <= imem.exists(inst_a2) ? imem[inst_a2] : 32'd0;
        data_rd2 <= dmem.exists(data_a2) ? dmem[data_a2] : 32'd0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard, sampled on the falling edge
    logic        prev_ov = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_od = 32'd0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_we2_zero", {28'd0, data_we2}, 32'd0);
            check("cpu_rst_req_eq_busy", {31'd0, cpu_rst_req}, {31'd0, busy});
            if (inst_we2 != 4'h0) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: addr %h data %h we %h", inst_a2, inst_wd2, inst_we2);
                end else begin
                    logic [63:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", inst_a2, e[63:32]);
                    check("wr_data", inst_wd2, e[31:0]);
                    check("wr_we", {28'd0, inst_we2}, 32'hF);
                end
            end
            if (prev_ov && !prev_hs) begin
                check("out_valid_held", {31'd0, out_valid}, 32'd1);
                check("out_data_stable", out_data, prev_od);
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_dump: data %h", out_data);
                end else begin
                    check("dump_data", out_data, exp_out.pop_front());
                end
            end
        end
        prev_ov = out_valid;
        prev_hs = out_valid && out_ready;
        prev_od = out_data;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [31:0] b, input logic [15:0] n);
        start = 1'b1; mode = m; base_addr = b; word_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 50 && !in_ready; t++) tick();
        check("in_ready_seen", {31'd0, in_ready}, 32'd1);
        exp_wr.push_back({a, d});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic run_load(input logic [31:0] base, input bit mid_start);
        logic [31:0] wx, rx;
        wx = 32'd0;
        rx = 32'd0;
        for (int k = 0; k < words_q.size(); k++) begin
            wx ^= words_q[k];
            rx ^= (corrupt_en && addrs_q[k] == corrupt_addr) ? corrupt_val : words_q[k];
        end
        do_start(1'b0, base, 16'(words_q.size()));
        for (int k = 0; k < words_q.size(); k++) begin
            send_word(addrs_q[k], words_q[k]);
            if (mid_start && k == 0) begin
                do_start(1'b1, 32'h40, 16'd5);
                check("busy_after_ignored_start", {31'd0, busy}, 32'd1);
            end
        end
        wait_done(100);
        check("verify_err", {31'd0, verify_err}, {31'd0, (wx != rx)});
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
        tick();
        check("cpu_rst_req_after_done", {31'd0, cpu_rst_req}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = 32'd0; word_count = 16'd0;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_inst_we2", {28'd0, inst_we2}, 32'd0);
        check("rst_inst_a2", inst_a2, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_verify_err", {31'd0, verify_err}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // load with unaligned base, clean verify
        words_q = '{32'h11, 32'h22, 32'h33};
        addrs_q = '{32'h100, 32'h104, 32'h108};
        run_load(32'h103, 1'b0);
        check("load_ok_err_literal", {31'd0, verify_err}, 32'd0);

        // load whose readback is corrupted at 0x104
        corrupt_en = 1'b1; corrupt_addr = 32'h104; corrupt_val = 32'h23;
        run_load(32'h103, 1'b0);
        corrupt_en = 1'b0;
        tick(); tick(); tick();
        check("verify_err_sticky", {31'd0, verify_err}, 32'd1);

        // zero count clears the sticky error and completes without port access
        do_start(1'b0, 32'h200, 16'd0);
        check("zero_verify_err_cleared", {31'd0, verify_err}, 32'd0);
        wait_done(2);
        tick();
        check("zero_busy_after", {31'd0, busy}, 32'd0);

        // dump with back-pressure
        dmem[32'h40] = 32'hAAAA5555;
        dmem[32'h44] = 32'h12345678;
        exp_out.push_back(32'hAAAA5555);
        exp_out.push_back(32'h12345678);
        out_ready = 1'b0;
        do_start(1'b1, 32'h40, 16'd2);
        for (int t = 0; t < 20 && !out_valid; t++) tick();
        check("dump_valid_seen", {31'd0, out_valid}, 32'd1);
        check("dump_first_literal", out_data, 32'hAAAA5555);
        repeat (5) tick();
        out_ready = 1'b1;
        wait_done(50);
        check("dump_drained", 32'(exp_out.size()), 32'd0);
        check("dump_verify_err", {31'd0, verify_err}, 32'd0);
        out_ready = 1'b0;
        tick();

        // reset in the middle of a 4-word load; the second word's write must never happen
        do_start(1'b0, 32'h300, 16'd4);
        send_word(32'h300, 32'hDEAD0001);
        in_valid = 1'b1;
        in_data  = 32'hDEAD0002;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_we", {28'd0, inst_we2}, 32'd0);
        check("mid_rst_cpu_rst_req", {31'd0, cpu_rst_req}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        tick();
        words_q = '{32'h11, 32'h22, 32'h33};
        addrs_q = '{32'h100, 32'h104, 32'h108};
        run_load(32'h100, 1'b0);

        // address wrap with an ignored start pulse mid-operation
        words_q = '{32'hCAFE0001, 32'hCAFE0002};
        addrs_q = '{32'hFFFFFFFC, 32'h00000000};
        run_load(32'hFFFFFFFC, 1'b1);
        check("wrap_err_literal", {31'd0, verify_err}, 32'd0);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
